// File: rtl/safety_core_periph_bridge.sv
// safety_core_periph_bridge
//   Bridges the safety core data port (req/gnt/rvalid) onto the register-interface
//   request/response bus feeding the core-local peripheral demux. It holds at most
//   one outstanding access and returns exactly one rvalid per granted request.
//
//   Optional feature macro: SAFETY_PERIPH_BRIDGE_TIMEOUT_EN
//     When defined, a REQ-state watchdog aborts an access after TimeoutCycles
//     cycles without reg_ready_i. The abort answers with err=1, rdata=0 and pulses
//     timeout_o. When undefined, REQ waits forever and timeout_o is tied low.
//
//   Ports
//     clk_i, rst_ni     clock, async active-low reset
//     data_req_i        core request
//     data_gnt_o        grant, combinational (IDLE or RESP with req high)
//     data_we_i/be_i/addr_i/wdata_i   request fields, captured on grant
//     data_rvalid_o     one-cycle response strobe
//     data_rdata_o/err_o              response payload, held between responses
//     reg_valid_o       register request valid (high in REQ)
//     reg_write_o/addr_o/wdata_o/wstrb_o  registered request fields
//     reg_rdata_i/error_i/ready_i     register response
//     timeout_o         one-cycle pulse, coincident with the aborted response
module safety_core_periph_bridge #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_addr_i,
  input  logic [31:0]          data_wdata_i,
  output logic                 data_rvalid_o,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o,
  output logic                 reg_valid_o,
  output logic                 reg_write_o,
  output logic [AddrWidth-1:0] reg_addr_o,
  output logic [31:0]          reg_wdata_o,
  output logic [3:0]           reg_wstrb_o,
  input  logic [31:0]          reg_rdata_i,
  input  logic                 reg_error_i,
  input  logic                 reg_ready_i,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic                 write;
    logic [AddrWidth-1:0] addr;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
  } req_t;

  state_e state_q, state_d;
  req_t   req_q;
  logic   gnt;
  logic   ready_hit;
  logic   abort;
  logic   timeout_q;

  // Byte-lane bits of the address are dropped on purpose (word-aligned bus).
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_addr_i;

  assign gnt       = data_req_i && (state_q == IDLE || state_q == RESP);
  assign ready_hit = (state_q == REQ) && reg_ready_i;

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef SAFETY_PERIPH_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_q;

  // Cleared on every grant so it starts at 0 on the first REQ cycle; counts
  // REQ cycles spent waiting. Expiry needs ready still low, so a ready that
  // lands in the expiry cycle takes the normal path.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (gnt) begin
      cnt_q <= '0;
    end else if (state_q == REQ && !reg_ready_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign abort = (state_q == REQ) && !reg_ready_i && (cnt_q == CntLast);
`else
  assign abort = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt) state_d = REQ;
      REQ:     if (ready_hit || abort) state_d = RESP;
      RESP:    state_d = gnt ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. reg_valid_o decodes the state register directly, so it
  // falls as soon as reset clears the state.
  always_comb begin
    data_gnt_o    = gnt;
    reg_valid_o   = (state_q == REQ);
    data_rvalid_o = (state_q == RESP);
  end

  // ---------------------------------------------------------------------------
  // Request capture: fields stay frozen for the whole REQ phase because
  // grant is impossible while in REQ.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= '0;
    end else if (gnt) begin
      req_q.write <= data_we_i;
      req_q.addr  <= {data_addr_i[AddrWidth-1:2], 2'b00};
      req_q.wdata <= data_wdata_i;
      req_q.wstrb <= data_we_i ? data_be_i : 4'b0000;
    end
  end

  assign reg_write_o = req_q.write;
  assign reg_addr_o  = req_q.addr;
  assign reg_wdata_o = req_q.wdata;
  assign reg_wstrb_o = req_q.wstrb;

  // ---------------------------------------------------------------------------
  // Response capture: payload is held until the next completion so the core
  // may sample it any time after rvalid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_rdata_o <= '0;
      data_err_o   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      timeout_q <= abort;
      if (ready_hit) begin
        data_rdata_o <= req_q.write ? 32'h0 : reg_rdata_i;
        data_err_o   <= reg_error_i;
      end else if (abort) begin
        data_rdata_o <= 32'h0;
        data_err_o   <= 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_safety_core_periph_bridge.sv
// Self-checking bench for safety_core_periph_bridge. Random single transactions,
// directed corner cases, a back-to-back burst, a mid-transaction reset and (when
// the timeout macro is defined) watchdog expiry. Expected values come from a
// transaction-level model of the bridge's rules.
module tb_safety_core_periph_bridge;

  localparam int TO = 4;
`ifdef SAFETY_PERIPH_BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        reg_valid_o;
  logic        reg_write_o;
  logic [31:0] reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic [31:0] reg_rdata_i;
  logic        reg_error_i;
  logic        reg_ready_i;
  logic        timeout_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  safety_core_periph_bridge #(
    .AddrWidth    (32),
    .TimeoutCycles(TO)
  ) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .data_req_i   (data_req_i),
    .data_gnt_o   (data_gnt_o),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .data_err_o   (data_err_o),
    .reg_valid_o  (reg_valid_o),
    .reg_write_o  (reg_write_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_wstrb_o  (reg_wstrb_o),
    .reg_rdata_i  (reg_rdata_i),
    .reg_error_i  (reg_error_i),
    .reg_ready_i  (reg_ready_i),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  // Unrelated request traffic presented while the bridge must not grant.
  task automatic scramble_req();
    data_we_i    = 1'($urandom);
    data_be_i    = 4'($urandom);
    data_addr_i  = $urandom;
    data_wdata_i = $urandom;
  endtask

  // One isolated transaction. Entered and left just after a rising edge with
  // the bridge idle. delay = number of REQ cycles before the ready cycle.
  task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rd, input logic er,
                         input int delay);
    bit          abrt;
    int          nrq;
    logic [31:0] e_addr, e_rd;
    logic [3:0]  e_strb;
    logic        e_err;
    abrt   = TO_EN && (delay >= TO);
    nrq    = abrt ? TO : delay + 1;
    e_addr = addr & 32'hFFFF_FFFC;
    e_strb = we ? be : 4'b0000;
    e_rd   = (abrt || we) ? 32'h0 : rd;
    e_err  = abrt ? 1'b1 : er;

    data_req_i   = 1'b1;
    data_we_i    = we;
    data_be_i    = be;
    data_addr_i  = addr;
    data_wdata_i = wdata;
    reg_ready_i  = 1'b0;
    @(negedge clk_i);
    chk("gnt_idle", 32'(data_gnt_o), 32'd1);
    chk("rvalid_idle", 32'(data_rvalid_o), 32'd0);
    @(posedge clk_i); #1;

    for (int k = 0; k < nrq; k++) begin
      data_req_i  = 1'b1;
      scramble_req();
      reg_ready_i = (k == delay);
      reg_rdata_i = (k == delay) ? rd : $urandom;
      reg_error_i = (k == delay) ? er : 1'($urandom);
      @(negedge clk_i);
      chk("req_valid", 32'(reg_valid_o), 32'd1);
      chk("req_gnt_low", 32'(data_gnt_o), 32'd0);
      chk("req_rvalid_low", 32'(data_rvalid_o), 32'd0);
      chk("req_addr", reg_addr_o, e_addr);
      chk("req_write", 32'(reg_write_o), 32'(we));
      chk("req_wdata", reg_wdata_o, wdata);
      chk("req_wstrb", 32'(reg_wstrb_o), 32'(e_strb));
      @(posedge clk_i); #1;
    end

    data_req_i  = 1'b0;
    reg_ready_i = 1'($urandom);
    reg_rdata_i = $urandom;
    reg_error_i = 1'($urandom);
    @(negedge clk_i);
    chk("resp_rvalid", 32'(data_rvalid_o), 32'd1);
    chk("resp_rdata", data_rdata_o, e_rd);
    chk("resp_err", 32'(data_err_o), 32'(e_err));
    chk("resp_timeout", 32'(timeout_o), 32'(abrt));
    chk("resp_valid_low", 32'(reg_valid_o), 32'd0);
    @(posedge clk_i); #1;

    // A late ready here must have no effect.
    reg_ready_i = 1'b1;
    @(negedge clk_i);
    chk("post_rvalid", 32'(data_rvalid_o), 32'd0);
    chk("post_valid", 32'(reg_valid_o), 32'd0);
    chk("post_rdata_hold", data_rdata_o, e_rd);
    chk("post_err_hold", 32'(data_err_o), 32'(e_err));
    chk("post_timeout", 32'(timeout_o), 32'd0);
    @(posedge clk_i); #1;
    reg_ready_i = 1'b0;
  endtask

  // req held high with an always-ready target: a grant every other cycle.
  task automatic run_burst();
    logic [31:0] addr_h[9];
    logic [31:0] rd_h[9];
    int          n_gnt, n_rv;
    bit          e_gnt, e_rv;
    n_gnt = 0;
    n_rv  = 0;
    for (int c = 0; c < 9; c++) begin
      addr_h[c]    = $urandom;
      rd_h[c]      = $urandom;
      data_req_i   = (c < 8);
      data_we_i    = 1'b0;
      data_be_i    = 4'($urandom);
      data_addr_i  = addr_h[c];
      data_wdata_i = $urandom;
      reg_ready_i  = 1'b1;
      reg_error_i  = 1'b0;
      reg_rdata_i  = rd_h[c];
      e_gnt = (c % 2 == 0) && (c < 8);
      e_rv  = (c % 2 == 0) && (c > 0);
      @(negedge clk_i);
      chk("b2b_gnt", 32'(data_gnt_o), 32'(e_gnt));
      chk("b2b_rvalid", 32'(data_rvalid_o), 32'(e_rv));
      if (c % 2 == 1) chk("b2b_addr", reg_addr_o, addr_h[c-1] & 32'hFFFF_FFFC);
      if (e_rv) chk("b2b_rdata", data_rdata_o, rd_h[c-1]);
      if (data_gnt_o) n_gnt++;
      if (data_rvalid_o) n_rv++;
      @(posedge clk_i); #1;
    end
    data_req_i  = 1'b0;
    reg_ready_i = 1'b0;
    chk("b2b_n_gnt", 32'(n_gnt), 32'd4);
    chk("b2b_n_rvalid", 32'(n_rv), 32'd4);
  endtask

  task automatic run_reset_mid();
    data_req_i   = 1'b1;
    data_we_i    = 1'b1;
    data_be_i    = 4'hF;
    data_addr_i  = 32'h0000_0200;
    data_wdata_i = 32'hCAFE_F00D;
    reg_ready_i  = 1'b0;
    @(posedge clk_i); #1;
    data_req_i = 1'b0;
    @(negedge clk_i);
    chk("rst_pre_valid", 32'(reg_valid_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    chk("rst_async_valid", 32'(reg_valid_o), 32'd0);
    chk("rst_async_addr", reg_addr_o, 32'h0);
    chk("rst_async_wdata", reg_wdata_o, 32'h0);
    chk("rst_async_strb", 32'(reg_wstrb_o), 32'd0);
    chk("rst_async_write", 32'(reg_write_o), 32'd0);
    chk("rst_async_rdata", data_rdata_o, 32'h0);
    chk("rst_async_rvalid", 32'(data_rvalid_o), 32'd0);
    reg_ready_i = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      chk("rst_no_rvalid", 32'(data_rvalid_o), 32'd0);
      chk("rst_no_valid", 32'(reg_valid_o), 32'd0);
    end
    @(posedge clk_i); #1;
    reg_ready_i = 1'b0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    reg_rdata_i  = 32'h0;
    reg_error_i  = 1'b0;
    reg_ready_i  = 1'b0;
    #12;
    chk("reset_valid", 32'(reg_valid_o), 32'd0);
    chk("reset_rvalid", 32'(data_rvalid_o), 32'd0);
    chk("reset_rdata", data_rdata_o, 32'h0);
    chk("reset_err", 32'(data_err_o), 32'd0);
    chk("reset_addr", reg_addr_o, 32'h0);
    chk("reset_timeout", 32'(timeout_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Directed cases
    run_txn(1'b0, 4'hF, 32'h0000_0107, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    run_txn(1'b1, 4'b0110, 32'h0000_0040, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 5);
    run_txn(1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h0BAD_0BAD, 1'b1, 1);
    run_txn(1'b1, 4'b0000, 32'h0000_0013, 32'hA5A5_A5A5, 32'h0, 1'b0, 0);
    if (TO_EN) begin
      run_txn(1'b0, 4'h0, 32'h0000_0080, 32'h0, 32'h1111_2222, 1'b0, 100);
      run_txn(1'b0, 4'h0, 32'h0000_0084, 32'h0, 32'h3333_4444, 1'b0, TO - 1);
      run_txn(1'b1, 4'h3, 32'h0000_0088, 32'h5555_6666, 32'h0, 1'b1, TO);
    end

    run_burst();
    run_reset_mid();
    run_txn(1'b0, 4'h0, 32'h0000_0204, 32'h0, 32'h7777_8888, 1'b0, 0);

    // Random transactions
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), 4'($urandom), $urandom, $urandom, $urandom,
              1'($urandom), int'($urandom_range(0, TO_EN ? TO + 1 : 6)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
